// File: rtl/riscv_div_pkg.sv
// Shared types and constants for the iterative divider.
package riscv_div_pkg;
  localparam int XLEN  = 64;
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] DIV0_QUOT = '1;

  typedef enum logic [2:0] {IDLE, SIGN_IN, CALC, SIGN_OUT, DONE} div_state_e;
endpackage

// File: rtl/bit_Adder.sv
// W-bit ripple-style adder with carry in/out.
module bit_Adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/bit_Subtractor.sv
// W-bit subtractor a - b; cout=1 means no borrow (a >= b unsigned).
module bit_Subtractor #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         cout
);
  assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
endmodule

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: dout = neg ? -din : din.
module div_sign_fix
  import riscv_div_pkg::*;
(
  input  logic [XLEN-1:0] din,
  input  logic            neg,
  output logic [XLEN-1:0] dout
);
  logic [XLEN-1:0] negated;
  logic            unused_cout;

  bit_Adder #(.W(XLEN)) u_add (
    .a   (~din),
    .b   ({XLEN{1'b0}}),
    .cin (1'b1),
    .sum (negated),
    .cout(unused_cout)
  );

  assign dout = neg ? negated : din;
endmodule

// File: rtl/iter_divider_ctrl.sv
// Iterative 64-bit restoring divider, one quotient bit per clock, RISC-V M semantics.
// Define DIV_SIGNED_EN to honour div_signed (adds SIGN_IN/SIGN_OUT states).
module iter_divider_ctrl
  import riscv_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            div_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero,
  output logic            busy
);
  div_state_e       state;
  logic [XLEN-1:0]  rem, q, dvsr;
  logic [CNT_W-1:0] cnt;

  logic [XLEN-1:0]  shifted, diff, next_rem, next_q;
  logic             no_borrow, take, last_step;

  assign shifted = {rem[XLEN-2:0], q[XLEN-1]};

  bit_Subtractor #(.W(XLEN)) u_sub (
    .a   (shifted),
    .b   (dvsr),
    .diff(diff),
    .cout(no_borrow)
  );

  // rem[63] set means the 65-bit shifted value already exceeds any divisor
  assign take      = rem[XLEN-1] | no_borrow;
  assign next_rem  = take ? diff : shifted;
  assign next_q    = {q[XLEN-2:0], take};
  assign last_step = (cnt == CNT_W'(1));

`ifdef DIV_SIGNED_EN
  logic            sgn_op, neg_q, neg_r;
  logic [XLEN-1:0] fa_in, fb_in, fa_out, fb_out;
  logic            fa_neg, fb_neg;

  // Two negators shared: operand abs() in SIGN_IN, result fix-up in SIGN_OUT
  always_comb begin
    fa_in  = q;
    fa_neg = neg_q;
    fb_in  = rem;
    fb_neg = neg_r;
    if (state == SIGN_IN) begin
      fa_neg = q[XLEN-1];
      fb_in  = dvsr;
      fb_neg = dvsr[XLEN-1];
    end
  end

  div_sign_fix u_fix_a (.din(fa_in), .neg(fa_neg), .dout(fa_out));
  div_sign_fix u_fix_b (.din(fb_in), .neg(fb_neg), .dout(fb_out));
`else
  logic unused_div_signed;
  assign unused_div_signed = div_signed;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      rem         <= '0;
      q           <= '0;
      dvsr        <= '0;
`ifdef DIV_SIGNED_EN
      sgn_op      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            q        <= dividend;
            dvsr     <= divisor;
            rem      <= '0;
            cnt      <= CNT_W'(XLEN);
            if (divisor == '0) begin
              quotient    <= DIV0_QUOT;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
              sgn_op <= div_signed;
              state  <= div_signed ? SIGN_IN : CALC;
`else
              state  <= CALC;
`endif
            end
          end
        end
`ifdef DIV_SIGNED_EN
        SIGN_IN: begin
          q     <= fa_out;
          dvsr  <= fb_out;
          neg_q <= q[XLEN-1] ^ dvsr[XLEN-1];
          neg_r <= q[XLEN-1];
          state <= CALC;
        end
`endif
        CALC: begin
          rem <= next_rem;
          q   <= next_q;
          cnt <= cnt - 1'b1;
          if (last_step) begin
`ifdef DIV_SIGNED_EN
            if (sgn_op) begin
              state <= SIGN_OUT;
            end else begin
              quotient  <= next_q;
              remainder <= next_rem;
              out_valid <= 1'b1;
              state     <= DONE;
            end
`else
            quotient  <= next_q;
            remainder <= next_rem;
            out_valid <= 1'b1;
            state     <= DONE;
`endif
          end
        end
`ifdef DIV_SIGNED_EN
        SIGN_OUT: begin
          quotient  <= fa_out;
          remainder <= fb_out;
          out_valid <= 1'b1;
          state     <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
